// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Iterative shift controller for the CPU's 8-bit shift unit. An accepted
//   instruction is executed one bit position per clock. Completion is
//   reported with a one-cycle done pulse. Immediate, zero-amount and
//   illegal ops complete in a single cycle without shifting.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start_i     request, sampled only while idle
//   instr_i     [AMTW+2:3] shift amount, [2:0] op
//               (000 LSL, 001 LSR, 010 RSR, 011 RSL, 100 ASR, 101-111 illegal)
//   imm_i       immediate: result is in_data_i unchanged
//   in_data_i   operand, sampled with start_i
//   busy_o      operation in progress (accept+1 through done cycle)
//   done_o      one-cycle completion pulse
//   out_data_o  result, valid with done_o, held until the next accept
//   carry_o     last bit shifted out or wrapped
//   zero_o      out_data_o == 0, valid with done_o, held
//   illegal_o   op was 101-111 (non-immediate), valid with done_o, held
//
// WIDTH must equal 2**AMTW.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMTW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [AMTW+2:0]   instr_i,
    input  logic              imm_i,
    input  logic [WIDTH-1:0]  in_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [WIDTH-1:0]  out_data_o,
    output logic              carry_o,
    output logic              zero_o,
    output logic              illegal_o
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_RSR = 3'b010;
    localparam logic [2:0] OP_RSL = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;

    state_t            state_q, state_d;
    logic [AMTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [2:0]        op_q, op_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;

    logic [2:0]        op_in;
    logic [AMTW-1:0]   amt_in;
    logic              op_bad;
    logic [WIDTH-1:0]  step_w;
    logic              step_c;

    assign op_in  = instr_i[2:0];
    assign amt_in = instr_i[AMTW+2:3];
    assign op_bad = (op_in > OP_ASR);

    // One-bit step of the latched op on the work register.
    always_comb begin
        step_w = work_q;
        step_c = carry_q;
        case (op_q)
            OP_LSL: begin step_w = {work_q[WIDTH-2:0], 1'b0};            step_c = work_q[WIDTH-1]; end
            OP_LSR: begin step_w = {1'b0, work_q[WIDTH-1:1]};            step_c = work_q[0];       end
            OP_ASR: begin step_w = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; step_c = work_q[0];       end
            OP_RSR: begin step_w = {work_q[0], work_q[WIDTH-1:1]};       step_c = work_q[0];       end
            OP_RSL: begin step_w = {work_q[WIDTH-2:0], work_q[WIDTH-1]}; step_c = work_q[WIDTH-1]; end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        op_d      = op_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    work_d    = in_data_i;
                    op_d      = op_in;
                    cnt_d     = amt_in;
                    carry_d   = 1'b0;
                    // Immediate mode overrides op decoding entirely.
                    illegal_d = ~imm_i & op_bad;
                    if (imm_i || amt_in == '0 || op_bad) begin
                        state_d = DONE;
                        zero_d  = (in_data_i == '0);
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d  = step_w;
                carry_d = step_c;
                cnt_d   = cnt_q - AMTW'(1);
                if (cnt_q == AMTW'(1)) begin
                    state_d = DONE;
                    zero_d  = (step_w == '0);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            op_q      <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs are direct register values or decodes of the state register.
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign out_data_o = work_q;
    assign carry_o    = carry_q;
    assign zero_o     = zero_q;
    assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [5:0] instr_i = '0;
    logic       imm_i = 1'b0;
    logic [7:0] in_data_i = '0;
    logic       busy_o, done_o, carry_o, zero_o, illegal_o;
    logic [7:0] out_data_o;

    int n_chk = 0;
    int n_fail = 0;

    shift_sequencer #(.WIDTH(8), .AMTW(3)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .instr_i(instr_i),
        .imm_i(imm_i), .in_data_i(in_data_i), .busy_o(busy_o), .done_o(done_o),
        .out_data_o(out_data_o), .carry_o(carry_o), .zero_o(zero_o),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-amount shift computed in one go with integer arithmetic.
    task automatic model(input logic im, input logic [2:0] op, input int n, input int x,
                         output int r, output int c, output int il, output int lat);
        int sx;
        r = x; c = 0; il = 0;
        lat = (im || n == 0 || op > 3'd4) ? 1 : n + 1;
        if (!im && op > 3'd4) il = 1;
        else if (!im && n != 0) begin
            case (op)
                3'd0: begin r = (x << n) & 255; c = (x >> (8 - n)) & 1; end
                3'd1: begin r = x >> n;          c = (x >> (n - 1)) & 1; end
                3'd4: begin
                    sx = (x >= 128) ? x - 256 : x;
                    r = (sx >>> n) & 255;        c = (x >> (n - 1)) & 1;
                end
                3'd2: begin r = ((x >> n) | (x << (8 - n))) & 255; c = (r >> 7) & 1; end
                3'd3: begin r = ((x << n) | (x >> (8 - n))) & 255; c = r & 1; end
                default: ;
            endcase
        end
    endtask

    // Called at a negedge in an idle cycle. Returns at the negedge of the done
    // cycle. poke_cyc>0 pulses start with 0xFF data while busy.
    task automatic do_op(input string tag, input logic im, input logic [2:0] op,
                         input logic [2:0] amt, input logic [7:0] d, input int poke_cyc);
        int r, c, il, lat, cyc;
        bit busy_ok, got;
        model(im, op, int'(amt), int'(d), r, c, il, lat);
        start_i = 1'b1; imm_i = im; instr_i = {amt, op}; in_data_i = d;
        @(posedge clk); #1;
        start_i = 1'b0;
        busy_ok = 1'b1; got = 1'b0; cyc = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (!busy_o) busy_ok = 1'b0;
            if (done_o) begin got = 1'b1; cyc = k; end
            if (k == poke_cyc) begin start_i = 1'b1; in_data_i = 8'hFF; imm_i = 1'b1; end
            else start_i = 1'b0;
        end
        start_i = 1'b0;
        check({tag, " done seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " busy"}, 32'(busy_ok), 32'd1);
        check({tag, " data"}, 32'(out_data_o), 32'(r));
        check({tag, " carry"}, 32'(carry_o), 32'(c));
        check({tag, " zero"}, 32'(zero_o), 32'(r == 0));
        check({tag, " illegal"}, 32'(illegal_o), 32'(il));
    endtask

    // Advance to the following idle cycle and confirm the pulse ended.
    task automatic to_idle(input string tag);
        @(negedge clk);
        check({tag, " idle busy"}, 32'(busy_o), 32'd0);
        check({tag, " idle done"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        logic [7:0] held;
        // Reset state
        #1;
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst data", 32'(out_data_o), 32'd0);
        check("rst flags", 32'({carry_o, zero_o, illegal_o}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        do_op("lsl b5/3", 1'b0, 3'd0, 3'd3, 8'hB5, 0); to_idle("lsl");
        do_op("asr 90/2", 1'b0, 3'd4, 3'd2, 8'h90, 0); to_idle("asr");
        do_op("lsr 0f/4", 1'b0, 3'd1, 3'd4, 8'h0F, 0); to_idle("lsr");
        do_op("rsr 01/1", 1'b0, 3'd2, 3'd1, 8'h01, 0); to_idle("rsr");
        do_op("rsl 01/7", 1'b0, 3'd3, 3'd7, 8'h01, 0); to_idle("rsl7");
        do_op("rsl 96/0", 1'b0, 3'd3, 3'd0, 8'h96, 0); to_idle("rsl0");
        do_op("imm 3c", 1'b1, 3'd0, 3'd7, 8'h3C, 0); to_idle("imm");
        do_op("ill 5a", 1'b0, 3'd5, 3'd3, 8'h5A, 0); to_idle("ill");
        do_op("ignored start", 1'b0, 3'd0, 3'd5, 8'h01, 2);
        to_idle("ignored");
        @(negedge clk);
        check("no extra done", 32'(done_o), 32'd0);
        check("ignored data held", 32'(out_data_o), 32'h20);

        // start during the done cycle must not be accepted
        do_op("pre dcyc", 1'b0, 3'd1, 3'd2, 8'hC0, 0);
        held = out_data_o;
        start_i = 1'b1; imm_i = 1'b1; in_data_i = 8'h77;
        @(negedge clk);
        start_i = 1'b0;
        check("done-cycle start busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("done-cycle start busy2", 32'(busy_o), 32'd0);
        check("done-cycle start data", 32'(out_data_o), 32'(held));

        // Reset abort in the middle of a 7-bit shift
        start_i = 1'b1; imm_i = 1'b0; instr_i = {3'd7, 3'd3}; in_data_i = 8'hFF;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy_o), 32'd0);
        check("abort done", 32'(done_o), 32'd0);
        check("abort data", 32'(out_data_o), 32'd0);
        check("abort flags", 32'({carry_o, zero_o, illegal_o}), 32'd0);
        @(negedge clk); @(negedge clk);
        check("abort no done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("lsr 80/7", 1'b0, 3'd1, 3'd7, 8'h80, 0); to_idle("post abort");

        // Randomized back-to-back operations
        for (int i = 0; i < 40; i++) begin
            logic im;
            logic [2:0] op, amt;
            logic [7:0] d;
            im  = ($urandom_range(0, 7) == 0);
            op  = 3'($urandom_range(0, 7));
            amt = 3'($urandom_range(0, 7));
            d   = 8'($urandom);
            do_op($sformatf("rnd%0d", i), im, op, amt, d, 0);
            to_idle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Iterative shift controller for the 8-bit shift unit of the multi-cycle CPU. It accepts a shift instruction from the control FSM and executes it one bit position per clock. It reports completion with a one-cycle done pulse, and produces the result plus carry, zero and illegal-op status for the flag register. Immediate-mode instructions bypass shifting and complete in one cycle.

## Interface
- WIDTH, 8, data width; fixed at 8 for this CPU.
- AMTW, 3, shift-amount field width; WIDTH must equal 2**AMTW.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- instr  input  AMTW+3  [AMTW+2:3] shift amount; [2:0] op: 000 LSL, 001 LSR, 010 RSR (rotate right), 011 RSL (rotate left), 100 ASR, 101–111 illegal.
- imm  input  1  1 = immediate instruction; result is in_data unchanged.
- in_data  input  WIDTH  operand, sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- out_data  output  WIDTH  result; valid when done=1, held until next accepted start.
- carry  output  1  last bit shifted out, or last bit wrapped for rotates; held with out_data.
- zero  output  1  out_data==0; valid with done, held.
- illegal  output  1  op was 101–111; valid with done, held.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1: latch in_data into the work register, latch op, latch amount into down-counter cnt, and clear carry and illegal.
  - Go to DONE if imm=1, amount=0, or op is illegal.
  - Otherwise go to SHIFT.
- SHIFT: each cycle, apply a one-bit step to the work register and decrement cnt. Go to DONE when cnt reaches 0 after the step.
- One-bit steps:
  - LSL: {w[6:0],0}, carry=w[7].
  - LSR: {0,w[7:1]}, carry=w[0].
  - ASR: {w[7],w[7:1]}, carry=w[0].
  - RSR: {w[0],w[7:1]}, carry=w[0].
  - RSL: {w[6:0],w[7]}, carry=w[7].
- DONE: done=1 for this cycle only; zero reflects the final work register. Return to IDLE.
- Result equals a single-cycle shift of in_data by the full amount.
- imm=1 overrides op decoding: out_data=in_data, carry=0, illegal=0.
- Illegal op (imm=0): out_data=in_data, carry=0, illegal=1.
- start while busy=1 is ignored with no queuing. start in the DONE cycle is ignored; the earliest new accept is the following IDLE cycle.
- out_data, carry, zero and illegal may change during SHIFT; consumers sample only on done.
- Reset (asynchronous, any state, including mid-shift): state=IDLE, cnt=0, work register=0, busy=0, done=0, carry=0, zero=0, illegal=0. out_data=0. The aborted operation produces no done.

## Timing
- Accept at edge T (start=1, IDLE). busy=1 from T+1 through the DONE cycle inclusive. done=1 in cycle T+1+n, where n = amount for legal non-imm shifts and n=0 otherwise.
- Latency: amount+1 cycles; minimum 1 cycle (imm, amount 0, illegal); maximum 8 cycles (amount 7).
- Back-to-back throughput: one operation per amount+2 cycles (IDLE cycle between operations).
- busy falls and IDLE is re-entered at the edge after the done cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- LSL: in_data=0xB5, amount 3, start at T -> done at T+4, out_data=0xA8, carry=1, zero=0, busy high T+1..T+4.
- ASR and LSR with flags:
  - ASR 0x90, amount 2 -> 0xE4, carry=0.
  - LSR 0x0F, amount 4 -> 0x00, carry=1, zero=1, done at T+5.
- Rotates:
  - RSR 0x01, amount 1 -> 0x80, carry=1.
  - RSL 0x01, amount 7 -> 0x80, carry=0, done at T+8.
  - RSL 0x96, amount 0 -> 0x96, done at T+1.
- Bypass and illegal:
  - imm=1, instr=6'b111_000, in_data=0x3C -> 0x3C, carry=0, illegal=0, done at T+1.
  - imm=0, op 101, in_data=0x5A -> 0x5A, illegal=1, done at T+1.
- Ignored start: during LSL amount 5 on 0x01, pulse start at T+2 with in_data=0xFF -> result is still 0x20 at T+6; no extra done.
- Reset abort: assert rst_n=0 at T+3 of a 7-bit shift -> all outputs 0 immediately and no done. After release, LSR 0x80 amount 7 -> 0x01, carry=0, done at accept+8.
